// File: rtl/ps2_command_sender.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device clock edges with odd parity, stop bit and acknowledge check.
module ps2_command_sender #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timed_out,
    output logic       error_no_ack
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_RELEASE
    } state_t;

    state_t      state, state_next;
    logic [7:0]  cmd_reg, cmd_next;
    logic        parity_reg, parity_next;
    logic [3:0]  bit_count, bit_next;
    logic [31:0] count, count_next;
    logic        drive_clk, drive_clk_next;
    logic        drive_dat, drive_dat_next;
    logic        busy_next, done_next, timeout_next, noack_next;

    logic [1:0]  clk_sync, dat_sync;
    logic        clk_prev;
    logic        clk_s, dat_s, fall, rise;

    // Only ever pull low; a released line is brought high by the bus pull-up.
    assign PS2_CLK = drive_clk ? 1'b0 : 1'bz;
    assign PS2_DAT = drive_dat ? 1'b0 : 1'bz;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign fall  = clk_prev & ~clk_s;
    assign rise  = ~clk_prev & clk_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cmd_reg          <= 8'h00;
            parity_reg       <= 1'b0;
            bit_count        <= 4'd0;
            count            <= 32'd0;
            drive_clk        <= 1'b0;
            drive_dat        <= 1'b0;
            busy             <= 1'b0;
            command_was_sent <= 1'b0;
            error_timed_out  <= 1'b0;
            error_no_ack     <= 1'b0;
        end else begin
            state            <= state_next;
            cmd_reg          <= cmd_next;
            parity_reg       <= parity_next;
            bit_count        <= bit_next;
            count            <= count_next;
            drive_clk        <= drive_clk_next;
            drive_dat        <= drive_dat_next;
            busy             <= busy_next;
            command_was_sent <= done_next;
            error_timed_out  <= timeout_next;
            error_no_ack     <= noack_next;
        end
    end

    always_comb begin
        state_next     = state;
        cmd_next       = cmd_reg;
        parity_next    = parity_reg;
        bit_next       = bit_count;
        count_next     = count;
        drive_clk_next = drive_clk;
        drive_dat_next = drive_dat;
        busy_next      = busy;
        done_next      = 1'b0;
        timeout_next   = 1'b0;
        noack_next     = 1'b0;

        // Every device-clocked state shares one watchdog that restarts on each fall.
        if (state == RTS || state == DATA || state == PARITY || state == STOP ||
            state == ACK || state == WAIT_RELEASE) begin
            if (fall) begin
                count_next = 32'd0;
            end else begin
                count_next = count + 32'd1;
            end
        end

        case (state)
            IDLE: begin
                drive_clk_next = 1'b0;
                drive_dat_next = 1'b0;
                busy_next      = 1'b0;
                if (send_command) begin
                    cmd_next       = command;
                    parity_next    = ~^command;
                    bit_next       = 4'd0;
                    count_next     = 32'd0;
                    drive_clk_next = 1'b1;
                    busy_next      = 1'b1;
                    state_next     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (count == 32'(INHIBIT_CYCLES - 1)) begin
                    count_next     = 32'd0;
                    drive_clk_next = 1'b0;
                    drive_dat_next = 1'b1;
                    state_next     = RTS;
                end else begin
                    count_next = count + 32'd1;
                end
            end
            RTS: begin
                if (fall) begin
                    drive_dat_next = ~cmd_reg[0];
                    bit_next       = 4'd1;
                    state_next     = DATA;
                end else if (count == 32'(START_TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                end
            end
            DATA: begin
                if (fall) begin
                    if (bit_count == 4'd8) begin
                        drive_dat_next = ~parity_reg;
                        state_next     = PARITY;
                    end else begin
                        drive_dat_next = ~cmd_reg[bit_count[2:0]];
                        bit_next       = bit_count + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    drive_dat_next = 1'b0;
                    state_next     = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (rise) begin
                    if (!dat_s) begin
                        state_next = WAIT_RELEASE;
                    end else begin
                        noack_next = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (clk_s && dat_s) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state != IDLE && state != INHIBIT && state != RTS && !fall &&
            count == 32'(BIT_TIMEOUT - 1)) begin
            timeout_next = 1'b1;
        end

        if (timeout_next) begin
            done_next      = 1'b0;
            noack_next     = 1'b0;
            drive_clk_next = 1'b0;
            drive_dat_next = 1'b0;
            busy_next      = 1'b0;
            count_next     = 32'd0;
            state_next     = IDLE;
        end
    end

endmodule

// File: doc/ps2_command_sender.md
# ps2_command_sender

Host-to-device PS/2 transmitter. It sends one 8-bit command byte to the keyboard, for example 0xED to set the LEDs or 0xFF to reset the keyboard. It shares the open-drain PS2_CLK/PS2_DAT lines with the scan-code receive path. It implements inhibit, request-to-send, device-clocked serialisation with odd parity, stop bit and device acknowledge, and reports completion or failure with one-cycle pulses.

## Interface
- INHIBIT_CYCLES, 5000: clock cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
- START_TIMEOUT, 750000: maximum cycles from request-to-send to the first device falling edge (15 ms).
- BIT_TIMEOUT, 100000: maximum cycles between consecutive device falling edges (2 ms).
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- command  in  8  byte to send; sampled when a send is accepted.
- send_command  in  1  one-cycle request; ignored unless idle.
- PS2_CLK  inout  1  open-drain; driven 0 or released (z).
- PS2_DAT  inout  1  open-drain; driven 0 or released (z).
- busy  out  1  high from acceptance until return to IDLE.
- command_was_sent  out  1  one-cycle pulse on successful acknowledge.
- error_timed_out  out  1  one-cycle pulse when START_TIMEOUT or BIT_TIMEOUT expires.
- error_no_ack  out  1  one-cycle pulse when the ack bit is sampled high.

## Operation
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer.
  - fall = previous synced clock 1 and current synced clock 0.
- Line drive: each line is low when its drive flag is 1; otherwise it is z. Flags are registered. Only low is ever driven.
- States and transitions:
  - IDLE: both lines released. On send_command, latch command, compute parity = ~^command (odd), clear counters, go to INHIBIT.
  - INHIBIT: drive PS2_CLK low for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: drive PS2_DAT low (start bit) and release PS2_CLK. Run the timeout counter against START_TIMEOUT. On the first fall, drive data bit 0 and go to DATA.
  - DATA: on each fall, put the next bit on the line; bit value 1 releases PS2_DAT, value 0 drives it low. Bits go out LSB first. After bit 7 is placed, the next fall places parity and the state goes to PARITY.
  - PARITY: on fall, release PS2_DAT (stop = 1) and go to STOP.
  - STOP: on fall, go to ACK.
  - ACK: on the next rising edge of the synced clock, sample synced PS2_DAT.
    - Sample 0: go to WAIT_RELEASE.
    - Sample 1: pulse error_no_ack and go to IDLE.
  - WAIT_RELEASE: when synced clock and synced data are both 1, pulse command_was_sent and go to IDLE.
- Timeouts:
  - The edge counter resets on every fall.
  - In RTS the limit is START_TIMEOUT; in DATA through WAIT_RELEASE it is BIT_TIMEOUT.
  - When the limit is reached: release both lines, pulse error_timed_out, go to IDLE.
- The bit counter is 4 bits, 0..8; it never wraps within a frame.
- send_command while busy is dropped; the latched command does not change.
- Simultaneous send_command and a completion pulse: the request is ignored (the block is not yet idle).

## Timing
- Reset values: state IDLE; both drive flags 0 (lines z); busy, command_was_sent, error_timed_out and error_no_ack all 0; counters 0. Reset acts asynchronously; a mid-frame reset releases both lines immediately.
- busy rises the cycle after send_command is sampled in IDLE.
- PS2_CLK low window: exactly INHIBIT_CYCLES cycles. PS2_DAT goes low on the same edge PS2_CLK is released.
- Data change: registered output, 1 cycle after fall is detected, which is 3 cycles after the pin falls.
- Done, timeout and no-ack pulses each last exactly one cycle. busy falls on the same edge the pulse asserts.
- Earliest next accept: the cycle after busy falls.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and acking → PS2_CLK low 5000 cycles; device samples start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1; command_was_sent pulses once; busy falls.
- Send 0xF4 → device samples data 0,0,1,0,1,1,1,1 and parity 0; success pulse.
- No device clock after RTS → error_timed_out pulses 750000 cycles after RTS entry; both lines z; busy 0.
- Device stops clocking after bit 3 → error_timed_out pulses 100000 cycles after the last fall.
- Device holds data high during the ack slot → error_no_ack pulses; no command_was_sent.
- Reset asserted mid-DATA → both lines z and all outputs 0 without waiting for a clock edge; a send_command of 0xFF pulsed while busy is dropped, and the frame in flight keeps its original byte.
